// File: rtl/fp_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode helpers
// for the FPU phase sequencer.
package fp_pkg;

  localparam logic [2:0] OP_AD = 3'd0;
  localparam logic [2:0] OP_SD = 3'd1;
  localparam logic [2:0] OP_MW = 3'd2;
  localparam logic [2:0] OP_DW = 3'd3;
  localparam logic [2:0] OP_AF = 3'd4;
  localparam logic [2:0] OP_SF = 3'd5;
  localparam logic [2:0] OP_MF = 3'd6;
  localparam logic [2:0] OP_DF = 3'd7;

  typedef enum logic [3:0] {
    FPS_IDLE,
    FPS_F2,
    FPS_F4,
    FPS_F5,
    FPS_F6,
    FPS_F7,
    FPS_F8,
    FPS_F9,
    FPS_F10,
    FPS_F13,
    FPS_DONE
  } fps_state_e;

  // The top opcode bit selects the floating-point half of the table.
  function automatic logic is_float(input logic [7:9] op);
    return op[7];
  endfunction

endpackage

// File: rtl/fps_if.sv
// Control/status bundle between instruction control, F-PS and F-PM.
// The master side drives requests and F-PM status; F-PS is the slave.
interface fps_if;
  logic        start;
  logic [7:9]  ir;
  logic        nrf;
  logic        fic_z;
  logic        nz;
  logic        f2_, f4_, f5_, f6_, f7_, f8_, f10_;
  logic        f9, f13;
  logic        strob_fp;
  logic        strob2_fp;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, ir, nrf, fic_z, nz,
    input  f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    input  strob_fp, strob2_fp, busy, done, err
  );

  modport slave (
    input  start, ir, nrf, fic_z, nz,
    output f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    output strob_fp, strob2_fp, busy, done, err
  );
endinterface

// File: rtl/fps_tick.sv
// Per-phase tick counter: wraps modulo PH_TICKS and produces the two
// phase strobes; held at zero while no phase is running.
module fps_tick #(
  parameter  int PH_TICKS = 4,
  localparam int TW       = $clog2(PH_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] tick,
  output logic          last_tick,
  output logic          strob_fp,
  output logic          strob2_fp
);

  logic [TW-1:0] r_tick;

  always_ff @(posedge clk) begin
    if (rst || clr)     r_tick <= '0;
    else if (last_tick) r_tick <= '0;
    else                r_tick <= r_tick + TW'(1);
  end

  assign tick      = r_tick;
  assign last_tick = !clr && (r_tick == TW'(PH_TICKS - 1));
  assign strob_fp  = !clr && (r_tick == TW'(1));
  assign strob2_fp = !clr && (r_tick == TW'(2));

endmodule

// File: rtl/fps.sv
// FPU phase sequencer: walks the per-opcode phase table driving F-PM,
// loops on F8/F13 using F-PM status, with an iteration watchdog.
module fps
  import fp_pkg::*;
#(
  parameter int PH_TICKS = 4,
  parameter int MAX_ITER = 63
) (
  input  logic  __clk,
  input  logic  _0_f,
  fps_if.slave  bus
);

  localparam int TW = $clog2(PH_TICKS);
  localparam int IW = $clog2(MAX_ITER + 1);

  fps_state_e     r_state, w_next;
  logic [7:9]     r_ir;
  logic [IW-1:0]  r_iter;
  logic           r_err;

  logic [TW-1:0]  w_tick;
  logic           w_last, w_strob, w_strob2, w_no_phase;
  logic           w_accept, w_repeat, w_abort;

  assign w_no_phase = (r_state == FPS_IDLE) || (r_state == FPS_DONE);

  fps_tick #(.PH_TICKS(PH_TICKS)) u_tick (
    .clk       (__clk),
    .rst       (_0_f),
    .clr       (w_no_phase),
    .tick      (w_tick),
    .last_tick (w_last),
    .strob_fp  (w_strob),
    .strob2_fp (w_strob2)
  );

  always_ff @(posedge __clk) begin
    if (_0_f) begin
      r_state <= FPS_IDLE;
      r_ir    <= '0;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ir  <= bus.ir;
        r_err <= 1'b0;
      end
      if (w_abort) r_err <= 1'b1;
      // Count only genuine repeats; any phase change or abort restarts it.
      if (w_last) r_iter <= (w_repeat && !w_abort) ? r_iter + IW'(1) : '0;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_repeat = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      FPS_IDLE: if (bus.start) begin
        w_accept = 1'b1;
        w_next   = bus.nrf ? FPS_F13 : FPS_F2;
      end
      FPS_DONE: w_next = FPS_IDLE;
      default: if (w_last) begin
        case (r_state)
          FPS_F2:  w_next = (r_ir == OP_AD || r_ir == OP_SD) ? FPS_F7 : FPS_F4;
          FPS_F4:  w_next = (r_ir == OP_AF || r_ir == OP_SF) ? FPS_F5 : FPS_F8;
          FPS_F5:  w_next = FPS_F8;
          FPS_F8: begin
            if (!bus.fic_z)                        w_repeat = 1'b1;
            else if (r_ir == OP_AF || r_ir == OP_SF) w_next = FPS_F6;
            else if (r_ir == OP_DF)                w_next   = FPS_F9;
            else                                   w_next   = FPS_F10;
          end
          FPS_F9:  w_next = FPS_F10;
          FPS_F10: w_next = (r_ir == OP_MW || r_ir == OP_DW) ? FPS_F7 : FPS_F6;
          FPS_F6:  w_next = FPS_F7;
          FPS_F7:  w_next = (is_float(r_ir) && bus.nz) ? FPS_F13 : FPS_DONE;
          FPS_F13: begin
            if (bus.nz) w_repeat = 1'b1;
            else        w_next   = FPS_DONE;
          end
          default: w_next = FPS_IDLE;
        endcase
        if (w_repeat && r_iter == IW'(MAX_ITER)) begin
          w_abort = 1'b1;
          w_next  = FPS_IDLE;
        end
      end
    endcase
  end

  assign bus.f2_       = (r_state != FPS_F2);
  assign bus.f4_       = (r_state != FPS_F4);
  assign bus.f5_       = (r_state != FPS_F5);
  assign bus.f6_       = (r_state != FPS_F6);
  assign bus.f7_       = (r_state != FPS_F7);
  assign bus.f8_       = (r_state != FPS_F8);
  assign bus.f10_      = (r_state != FPS_F10);
  assign bus.f9        = (r_state == FPS_F9);
  assign bus.f13       = (r_state == FPS_F13);
  assign bus.strob_fp  = w_strob;
  assign bus.strob2_fp = w_strob2;
  assign bus.busy      = (r_state != FPS_IDLE);
  assign bus.done      = (r_state == FPS_DONE);
  assign bus.err       = r_err;

  a_idle_tick_zero: assert property (@(posedge __clk) disable iff (_0_f)
    (r_state == FPS_IDLE) |-> (w_tick == '0));

endmodule

// File: tb/tb_fps.sv
// Directed bench for the FPU phase sequencer: each task walks one
// scenario cycle by cycle against hand-written phase tables.
module tb_fps;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  fps_if bus();

  fps #(.PH_TICKS(4), .MAX_ITER(63)) dut (
    .__clk (clk),
    ._0_f  (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Active phase number (2..13), 0 if none, -1 if more than one.
  function automatic int phase_of();
    int n = 0;
    int p = 0;
    if (!bus.f2_)  begin n++; p = 2;  end
    if (!bus.f4_)  begin n++; p = 4;  end
    if (!bus.f5_)  begin n++; p = 5;  end
    if (!bus.f6_)  begin n++; p = 6;  end
    if (!bus.f7_)  begin n++; p = 7;  end
    if (!bus.f8_)  begin n++; p = 8;  end
    if (bus.f9)    begin n++; p = 9;  end
    if (!bus.f10_) begin n++; p = 10; end
    if (bus.f13)   begin n++; p = 13; end
    return (n > 1) ? -1 : p;
  endfunction

  task automatic set_idle_inputs();
    bus.start = 1'b0; bus.ir = OP_AD; bus.nrf = 1'b0;
    bus.fic_z = 1'b0; bus.nz = 1'b0;
  endtask

  task automatic launch(input logic [2:0] op, input logic nrf_in);
    @(negedge clk);
    bus.ir = op; bus.nrf = nrf_in; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int ph;
    set_idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ph = phase_of();
    checks++;
    if (ph !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.strob_fp !== 1'b0 || bus.strob2_fp !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: phase=%0d busy=%b done=%b err=%b strobes=%b%b want all zero",
               ph, bus.busy, bus.done, bus.err, bus.strob_fp, bus.strob2_fp);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ph = phase_of();
      checks++;
      if (ph !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.strob_fp !== 1'b0 || bus.strob2_fp !== 1'b0) begin
        errs++;
        $display("FAIL idle_quiet c=%0d: phase=%0d busy=%b done=%b strobes=%b%b want quiet",
                 c, ph, bus.busy, bus.done, bus.strob_fp, bus.strob2_fp);
      end
    end
  endtask

  task automatic test_long_add();
    int exp_ph [2] = '{2, 7};
    int ph;
    bus.nz = 1'b1;
    launch(OP_AD, 1'b0);
    for (int c = 0; c < 8; c++) begin
      ph = phase_of();
      checks++;
      if (ph !== exp_ph[c/4] || bus.strob_fp !== (c % 4 == 1) ||
          bus.strob2_fp !== (c % 4 == 2) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errs++;
        $display("FAIL long_add c=%0d: phase=%0d s1=%b s2=%b busy=%b done=%b want phase=%0d",
                 c, ph, bus.strob_fp, bus.strob2_fp, bus.busy, bus.done, exp_ph[c/4]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || phase_of() !== 0 || bus.strob_fp !== 1'b0) begin
      errs++;
      $display("FAIL long_add_done: done=%b busy=%b phase=%0d want done=1 busy=1 phase=0",
               bus.done, bus.busy, phase_of());
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL long_add_idle: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    bus.nz = 1'b0;
  endtask

  task automatic test_af_shift_loop();
    int exp_ph [8] = '{2, 4, 5, 8, 8, 8, 6, 7};
    int ph;
    int pulses = 0;
    bus.nz = 1'b0; bus.fic_z = 1'b0;
    launch(OP_AF, 1'b0);
    for (int c = 0; c < 32; c++) begin
      ph = phase_of();
      if (bus.strob_fp === 1'b1) pulses++;
      checks++;
      if (ph !== exp_ph[c/4] || bus.strob_fp !== (c % 4 == 1) ||
          bus.strob2_fp !== (c % 4 == 2) || bus.done !== 1'b0) begin
        errs++;
        $display("FAIL af_seq c=%0d: phase=%0d s1=%b s2=%b done=%b want phase=%0d",
                 c, ph, bus.strob_fp, bus.strob2_fp, bus.done, exp_ph[c/4]);
      end
      bus.fic_z = (c / 4 >= 5);
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || pulses !== 8) begin
      errs++;
      $display("FAIL af_done: done=%b strob_fp_pulses=%0d want done=1 pulses=8", bus.done, pulses);
    end
    bus.fic_z = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_df_normalize();
    int exp_ph [10] = '{2, 4, 8, 9, 10, 6, 7, 13, 13, 13};
    int ph;
    bus.fic_z = 1'b1; bus.nz = 1'b1;
    launch(OP_DF, 1'b0);
    for (int c = 0; c < 40; c++) begin
      ph = phase_of();
      checks++;
      if (ph !== exp_ph[c/4] || bus.f9 !== (exp_ph[c/4] == 9) || bus.done !== 1'b0) begin
        errs++;
        $display("FAIL df_seq c=%0d: phase=%0d f9=%b done=%b want phase=%0d",
                 c, ph, bus.f9, bus.done, exp_ph[c/4]);
      end
      bus.nz = (c / 4 < 9);
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      errs++;
      $display("FAIL df_done: done=%b err=%b want 1 0", bus.done, bus.err);
    end
    bus.fic_z = 1'b0; bus.nz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nrf_direct();
    int ph;
    bus.nz = 1'b0;
    launch(OP_AF, 1'b1);
    for (int c = 0; c < 4; c++) begin
      ph = phase_of();
      checks++;
      if (ph !== 13) begin
        errs++;
        $display("FAIL nrf_seq c=%0d: phase=%0d want 13", c, ph);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errs++;
      $display("FAIL nrf_done: done=%b want 1", bus.done);
    end
    bus.nrf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int ph;
    int exp;
    bit seen;
    bus.fic_z = 1'b0;
    launch(OP_MW, 1'b0);
    for (int c = 0; c < 264; c++) begin
      ph  = phase_of();
      exp = (c < 4) ? 2 : (c < 8) ? 4 : 8;
      checks++;
      if (ph !== exp || bus.done !== 1'b0 || bus.err !== 1'b0) begin
        errs++;
        $display("FAIL wd_seq c=%0d: phase=%0d done=%b err=%b want phase=%0d", c, ph, bus.done, bus.err, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || phase_of() !== 0) begin
      errs++;
      $display("FAIL wd_abort: err=%b busy=%b done=%b phase=%0d want 1 0 0 0",
               bus.err, bus.busy, bus.done, phase_of());
    end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin
      errs++;
      $display("FAIL wd_sticky: err=%b want 1", bus.err);
    end
    bus.fic_z = 1'b1;
    launch(OP_MW, 1'b0);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1 || phase_of() !== 2) begin
      errs++;
      $display("FAIL wd_restart: err=%b busy=%b phase=%0d want 0 1 2", bus.err, bus.busy, phase_of());
    end
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = bus.done;
    end
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL wd_restart_done: no done within 100 cycles");
    end
    bus.fic_z = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int ph;
    launch(OP_AD, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.strob_fp !== 1'b1) begin
      errs++;
      $display("FAIL midop_strobe: strob_fp=%b want 1", bus.strob_fp);
    end
    rst = 1'b1;
    @(negedge clk);
    ph = phase_of();
    checks++;
    if (ph !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.strob_fp !== 1'b0 || bus.strob2_fp !== 1'b0) begin
      errs++;
      $display("FAIL midop_reset: phase=%0d busy=%b done=%b err=%b strobes=%b%b want all zero",
               ph, bus.busy, bus.done, bus.err, bus.strob_fp, bus.strob2_fp);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL midop_after: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_ph [5] = '{2, 4, 8, 10, 7};
    int ph;
    bus.fic_z = 1'b1; bus.nz = 1'b0;
    launch(OP_MW, 1'b0);
    for (int c = 0; c < 20; c++) begin
      ph = phase_of();
      checks++;
      if (ph !== exp_ph[c/4]) begin
        errs++;
        $display("FAIL busy_start c=%0d: phase=%0d want %0d", c, ph, exp_ph[c/4]);
      end
      // A request arriving mid-operation must not disturb the running sequence.
      bus.start = (c >= 4 && c < 8);
      bus.ir    = (c >= 4 && c < 8) ? OP_AD : OP_MW;
      bus.nrf   = (c >= 4 && c < 8);
      @(negedge clk);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done: done=%b want 1", bus.done);
    end
    bus.ir = OP_AD; bus.nrf = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || phase_of() !== 0) begin
      errs++;
      $display("FAIL b2b_done_start: busy=%b phase=%0d want 0 0", bus.busy, phase_of());
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || phase_of() !== 2) begin
      errs++;
      $display("FAIL b2b_accept: busy=%b phase=%0d want 1 2", bus.busy, phase_of());
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second_done: done=%b want 1", bus.done);
    end
    bus.fic_z = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_idle_inputs();
    test_reset();
    test_long_add();
    test_af_shift_loop();
    test_df_normalize();
    test_nrf_direct();
    test_watchdog();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fps.md
Name: fps

Overview:
- FPU phase sequencer (F-PS) that drives the F-PM microoperation unit through the phase signals f2_..f13 and the strobes strob_fp and strob2_fp.
- Latches the float/long opcode when a start request arrives and walks a fixed per-opcode phase sequence.
- Loops on the F8 shift phase and the F13 normalize phase, using status fed back from F-PM.
- Signals completion, or a watchdog error, back to the instruction control.

Parameters:
- PH_TICKS, 4: clock cycles per phase; legal range is 4 or more.
- MAX_ITER, 63: maximum consecutive iterations of a looping phase (F8 or F13) before the watchdog aborts.

Ports:
- __clk  in  1  system clock.
- _0_f  in  1  reset, synchronous, active-high.
- start  in  1  operation request; sampled only in IDLE.
- ir  in  [7:9]  opcode: 0=ad, 1=sd, 2=mw, 3=dw, 4=af, 5=sf, 6=mf, 7=df.
- nrf  in  1  normalize-only request; overrides ir when high at start.
- fic_z  in  1  F-PM shift counter exhausted.
- nz  in  1  F-PM result still needs normalization.
- f2_, f4_, f5_, f6_, f7_, f8_, f10_  out  1 each  phase active, active-low.
- f9, f13  out  1 each  phase active, active-high.
- strob_fp  out  1  primary phase strobe.
- strob2_fp  out  1  secondary phase strobe.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  watchdog abort; sticky until the next accepted start or reset.

Behaviour:
- Reset values:
  - All active-low phase outputs are 1; f9 and f13 are 0.
  - strob_fp, strob2_fp, busy, done and err are 0.
  - State is IDLE; tick counter and iteration counter are 0.
- Synchronous reset mid-operation: all outputs return to their reset values at the next edge, with no done pulse.
- States: IDLE, F2, F4, F5, F6, F7, F8, F9, F10, F13, DONE.
- Exactly one phase output is active in any phase state; none is active in IDLE or DONE.
- Phase timing, using a tick counter 0..PH_TICKS-1 that runs within each phase:
  - Tick 0: setup; phase output active, no strobe.
  - Tick 1: strob_fp=1.
  - Tick 2: strob2_fp=1.
  - Ticks 3..PH_TICKS-1: idle.
  - At the final tick, the next state is decided from the inputs sampled on that cycle.
- Start:
  - In IDLE with start=1: latch ir and nrf, clear err, set busy, enter F2 on the next cycle.
  - If nrf=1 at start, enter F13 directly instead of F2.
  - start outside IDLE is ignored.
- Transitions, evaluated at the final tick:
  - F2: ad/sd -> F7; all other opcodes -> F4.
  - F4: af/sf -> F5; mw/dw/mf/df -> F8.
  - F5 -> F8.
  - F8: if fic_z=0, repeat F8; if fic_z=1, af/sf -> F6, df -> F9, mw/dw/mf -> F10.
  - F9 -> F10.
  - F10: mw/dw -> F7; mf/df -> F6.
  - F6 -> F7.
  - F7: float op (ir[7]=1) with nz=1 -> F13; otherwise -> DONE.
  - F13: nz=1 -> repeat F13; nz=0 -> DONE.
- Watchdog:
  - The iteration counter increments on each repeat of F8 or F13 and clears on entry to any other phase.
  - When a repeat would make the count exceed MAX_ITER: set err=1, go to IDLE, deassert busy, no done pulse.
- DONE lasts exactly one cycle: done=1, busy still 1. IDLE follows with busy=0.
- A start asserted on the DONE cycle is ignored; start is accepted on the following IDLE cycle.
- Strobes are never asserted in IDLE or DONE.
- strob_fp and strob2_fp are never asserted on the same cycle.

Decomposition:
- Shared package fp_pkg holds:
  - opcode constants OP_AD..OP_DF (3-bit);
  - the state enum FPS_IDLE..FPS_DONE;
  - a helper function is_float(op) that returns op[7].
- One sub-module, fps_tick: a PH_TICKS-modulo phase tick counter.
  - Outputs: tick, last_tick, strob_fp, strob2_fp.
  - Synchronous clear on phase entry and on _0_f.

Test Plan:
- Reset and idle: hold _0_f=1 for 3 cycles, then release with no start -> f2_..f10_=1, f9=f13=0, busy=0, no strobes for 20 cycles.
- Long add: start=1 with ir=0 (ad) at cycle k -> F2 during k+1..k+4, F7 during k+5..k+8, done=1 at k+9, busy=0 at k+10.
- Float add with shift loop: start with ir=4 (af), nz=0, fic_z=0 for the first two F8 phases then 1 -> phases F2, F4, F5, F8, F8, F8, F6, F7; done at k+33; exactly 8 strob_fp pulses.
- df with normalization: start with ir=7; fic_z=1; nz=1 until two F13 phases have completed -> phases F2, F4, F8, F9, F10, F6, F7, F13, F13, F13; f9 low except during F9.
- Watchdog and restart: start with ir=2, fic_z held 0 -> err=1 after F8 has repeated 63 times (64 F8 phases total), busy=0, no done. A new start clears err.
- Reset mid-op and start during busy: assert _0_f during a strob_fp cycle -> next cycle all outputs at reset values. Separately, pulse start in F4 -> phase order unchanged.
